rs_alu_scheduler: RTL and testbench

- Reservation station and issue scheduler for the integer ALU in the Tomasulo core.
- Buffers decoded ALU-class instructions and captures operands from CDB broadcasts.
- Each cycle, selects one ready entry, drives it into the ALU, and registers the ALU outcome as a broadcast tagged with the ROB index.
- Sits between dispatch and the CDB/ROB; the ALU is purely combinational, so the ALU-input and result registers are owned here.

---
 rtl/rs_alu_scheduler_if.sv | 64 ++++++
 rtl/rs_alu_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_rs_alu_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs_alu_scheduler_if.sv
// Dispatch / CDB / ALU / result bundle around the ALU reservation station.
// Purely structural: no storage; timing is set by rs_alu_scheduler.
// Backpressure: rs_full tells dispatch to hold; there is no other stall path.
interface rs_alu_scheduler_if #(
  parameter int ROB_W = 4
);
  // dispatch side
  logic             issue_valid;
  logic [5:0]       issue_inst_name;
  logic [31:0]      issue_V1;
  logic [31:0]      issue_V2;
  logic             issue_Q1_busy;
  logic             issue_Q2_busy;
  logic [ROB_W-1:0] issue_Q1;
  logic [ROB_W-1:0] issue_Q2;
  logic [31:0]      issue_imm;
  logic [31:0]      issue_pc;
  logic [ROB_W-1:0] issue_rob_id;
  logic             rs_full;
  // common data bus
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0]      cdb_value;
  // combinational ALU, operands registered by the station
  logic [5:0]       alu_inst_name;
  logic [31:0]      alu_V1;
  logic [31:0]      alu_V2;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_pc;
  logic [31:0]      alu_result;
  logic [31:0]      alu_target_pc;
  logic             alu_jump;
  logic             alu_valid;
  // registered result broadcast
  logic             out_valid;
  logic [ROB_W-1:0] out_rob_id;
  logic [31:0]      out_result;
  logic [31:0]      out_target_pc;
  logic             out_jump;

  // station view
  modport slave (
    input  issue_valid, issue_inst_name, issue_V1, issue_V2,
           issue_Q1_busy, issue_Q2_busy, issue_Q1, issue_Q2,
           issue_imm, issue_pc, issue_rob_id,
           cdb_valid, cdb_rob_id, cdb_value,
           alu_result, alu_target_pc, alu_jump, alu_valid,
    output rs_full,
           alu_inst_name, alu_V1, alu_V2, alu_imm, alu_pc,
           out_valid, out_rob_id, out_result, out_target_pc, out_jump
  );

  // surrounding core view (dispatch, CDB, ALU, ROB)
  modport master (
    output issue_valid, issue_inst_name, issue_V1, issue_V2,
           issue_Q1_busy, issue_Q2_busy, issue_Q1, issue_Q2,
           issue_imm, issue_pc, issue_rob_id,
           cdb_valid, cdb_rob_id, cdb_value,
           alu_result, alu_target_pc, alu_jump, alu_valid,
    input  rs_full,
           alu_inst_name, alu_V1, alu_V2, alu_imm, alu_pc,
           out_valid, out_rob_id, out_result, out_target_pc, out_jump
  );
endinterface

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: buffers ops, captures CDB operands, issues oldest-index ready op.
// Latency: issue at edge k -> ALU inputs at edge k+1 -> out_* valid after edge k+2.
// Backpressure: rs_full (comb) blocks dispatch; rdy_in=0 freezes everything. Optional: RS_SELF_FORWARD_EN.
module rs_alu_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clr_in,
  rs_alu_scheduler_if.slave  bus
);

  localparam int         IDX_W = $clog2(RS_SIZE);
  localparam logic [5:0] NOP   = 6'd0;

  typedef struct packed {
    logic             busy;
    logic [5:0]       inst;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic             q1_busy;
    logic             q2_busy;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob;
  } entry_t;

  entry_t           ent     [RS_SIZE];
  entry_t           ent_nxt [RS_SIZE];
  logic             free_vld;
  logic [IDX_W-1:0] free_idx;
  logic             rdy_vld;
  logic [IDX_W-1:0] rdy_idx;
  logic             fwd_vld;

  logic [5:0]       alu_inst_q;
  logic [31:0]      alu_v1_q;
  logic [31:0]      alu_v2_q;
  logic [31:0]      alu_imm_q;
  logic [31:0]      alu_pc_q;
  logic [ROB_W-1:0] alu_rob_q;

  logic             out_vld_q;
  logic [ROB_W-1:0] out_rob_q;
  logic [31:0]      out_res_q;
  logic [31:0]      out_tgt_q;
  logic             out_jmp_q;

`ifdef RS_SELF_FORWARD_EN
  // our own registered result doubles as a second wakeup bus
  assign fwd_vld = out_vld_q;
`else
  assign fwd_vld = 1'b0;
`endif

  // Operand wakeup: returns {still_busy, value}; the CDB wins if both buses match.
  function automatic logic [32:0] wake(
    input logic             q_busy,
    input logic [ROB_W-1:0] q,
    input logic [31:0]      v,
    input logic             cdb_v,
    input logic [ROB_W-1:0] cdb_tag,
    input logic [31:0]      cdb_val,
    input logic             fwd_v,
    input logic [ROB_W-1:0] fwd_tag,
    input logic [31:0]      fwd_val
  );
    logic [32:0] r;
    r = {q_busy, v};
    if (q_busy && cdb_v && (q == cdb_tag)) begin
      r = {1'b0, cdb_val};
    end else if (q_busy && fwd_v && (q == fwd_tag)) begin
      r = {1'b0, fwd_val};
    end
    return r;
  endfunction

  // Lowest-index free slot and lowest-index ready slot, both from start-of-cycle state.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    rdy_vld  = 1'b0;
    rdy_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent[i].busy) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent[i].busy && !ent[i].q1_busy && !ent[i].q2_busy) begin
        rdy_vld = 1'b1;
        rdy_idx = IDX_W'(i);
      end
    end
  end

  assign bus.rs_full = !free_vld;

  // Next entry state: operand capture, free the dispatched slot, write the new op.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].busy) begin
        {ent_nxt[i].q1_busy, ent_nxt[i].v1} = wake(ent[i].q1_busy, ent[i].q1, ent[i].v1,
            bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, fwd_vld, out_rob_q, out_res_q);
        {ent_nxt[i].q2_busy, ent_nxt[i].v2} = wake(ent[i].q2_busy, ent[i].q2, ent[i].v2,
            bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, fwd_vld, out_rob_q, out_res_q);
      end
    end
    if (rdy_vld) begin
      ent_nxt[rdy_idx].busy = 1'b0;
    end
    // free_idx is never the dispatched slot: that one is busy at cycle start
    if (bus.issue_valid && free_vld) begin
      ent_nxt[free_idx].busy = 1'b1;
      ent_nxt[free_idx].inst = bus.issue_inst_name;
      ent_nxt[free_idx].q1   = bus.issue_Q1;
      ent_nxt[free_idx].q2   = bus.issue_Q2;
      ent_nxt[free_idx].imm  = bus.issue_imm;
      ent_nxt[free_idx].pc   = bus.issue_pc;
      ent_nxt[free_idx].rob  = bus.issue_rob_id;
      {ent_nxt[free_idx].q1_busy, ent_nxt[free_idx].v1} = wake(bus.issue_Q1_busy, bus.issue_Q1,
          bus.issue_V1, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, fwd_vld, out_rob_q, out_res_q);
      {ent_nxt[free_idx].q2_busy, ent_nxt[free_idx].v2} = wake(bus.issue_Q2_busy, bus.issue_Q2,
          bus.issue_V2, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, fwd_vld, out_rob_q, out_res_q);
    end
  end

  // Entry storage; flush empties the station.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= clr_in ? '0 : ent_nxt[i];
    end
  end

  // ALU input register: the selected ready op, or NOP when nothing is ready.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_inst_q <= NOP;
      alu_v1_q   <= '0;
      alu_v2_q   <= '0;
      alu_imm_q  <= '0;
      alu_pc_q   <= '0;
      alu_rob_q  <= '0;
    end else if (rdy_in) begin
      if (clr_in || !rdy_vld) begin
        alu_inst_q <= NOP;
      end else begin
        alu_inst_q <= ent[rdy_idx].inst;
        alu_v1_q   <= ent[rdy_idx].v1;
        alu_v2_q   <= ent[rdy_idx].v2;
        alu_imm_q  <= ent[rdy_idx].imm;
        alu_pc_q   <= ent[rdy_idx].pc;
        alu_rob_q  <= ent[rdy_idx].rob;
      end
    end
  end

  // Result register: captures the combinational ALU outcome tagged with its ROB index.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_vld_q <= 1'b0;
      out_rob_q <= '0;
      out_res_q <= '0;
      out_tgt_q <= '0;
      out_jmp_q <= 1'b0;
    end else if (rdy_in) begin
      if (clr_in) begin
        out_vld_q <= 1'b0;
      end else begin
        out_vld_q <= bus.alu_valid;
        out_rob_q <= alu_rob_q;
        out_res_q <= bus.alu_result;
        out_tgt_q <= bus.alu_target_pc;
        out_jmp_q <= bus.alu_jump;
      end
    end
  end

  assign bus.alu_inst_name = alu_inst_q;
  assign bus.alu_V1        = alu_v1_q;
  assign bus.alu_V2        = alu_v2_q;
  assign bus.alu_imm       = alu_imm_q;
  assign bus.alu_pc        = alu_pc_q;
  assign bus.out_valid     = out_vld_q;
  assign bus.out_rob_id    = out_rob_q;
  assign bus.out_result    = out_res_q;
  assign bus.out_target_pc = out_tgt_q;
  assign bus.out_jump      = out_jmp_q;

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Directed bench for rs_alu_scheduler with a small combinational ALU model.
// Inputs change #1 after the rising edge; outputs are checked at that point too.
// Covers reset, latency, CDB capture/bypass, full/refill, flush and rdy_in freeze.
module tb_rs_alu_scheduler;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd2;
  localparam logic [5:0] OP_BNE  = 6'd3;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clr_in;
  int   checks   = 0;
  int   failures = 0;

  rs_alu_scheduler_if #(.ROB_W(4)) bus ();

  rs_alu_scheduler #(.RS_SIZE(16), .ROB_W(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clr_in (clr_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // ALU stand-in: ADD, ADDI, BNE (result mirrors the taken flag)
  always_comb begin
    bus.alu_valid     = (bus.alu_inst_name != OP_NOP);
    bus.alu_result    = 32'd0;
    bus.alu_jump      = 1'b0;
    bus.alu_target_pc = 32'd0;
    case (bus.alu_inst_name)
      OP_ADD:  bus.alu_result = bus.alu_V1 + bus.alu_V2;
      OP_ADDI: bus.alu_result = bus.alu_V1 + bus.alu_imm;
      OP_BNE: begin
        bus.alu_jump      = (bus.alu_V1 != bus.alu_V2);
        bus.alu_result    = {31'd0, bus.alu_V1 != bus.alu_V2};
        bus.alu_target_pc = bus.alu_pc + bus.alu_imm;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic q1b, input logic [3:0] q1, input logic q2b, input logic [3:0] q2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    bus.issue_valid     = 1'b1;
    bus.issue_inst_name = op;
    bus.issue_V1        = v1;
    bus.issue_V2        = v2;
    bus.issue_Q1_busy   = q1b;
    bus.issue_Q1        = q1;
    bus.issue_Q2_busy   = q2b;
    bus.issue_Q2        = q2;
    bus.issue_imm       = imm;
    bus.issue_pc        = pc;
    bus.issue_rob_id    = rob;
  endtask

  task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_valid  = v;
    bus.cdb_rob_id = tag;
    bus.cdb_value  = val;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    clr_in = 1'b0;
    issue(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.issue_valid = 1'b0;
    cdb(0, 0, 0);
    repeat (2) tick();

    // reset state
    chk("rst_alu_inst", bus.alu_inst_name, OP_NOP);
    chk("rst_alu_v1", bus.alu_V1, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_rob", bus.out_rob_id, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_rs_full", bus.rs_full, 0);
    rst_in = 1'b1;
    tick();

    // ADDI 5+7, rob 3
    issue(OP_ADDI, 5, 0, 0, 0, 0, 0, 7, 0, 3);
    tick();
    bus.issue_valid = 1'b0;
    chk("addi_not_yet", bus.alu_inst_name, OP_NOP);
    tick();
    chk("addi_disp", bus.alu_inst_name, OP_ADDI);
    chk("addi_imm", bus.alu_imm, 7);
    tick();
    chk("addi_out_vld", bus.out_valid, 1);
    chk("addi_out_rob", bus.out_rob_id, 3);
    chk("addi_out_res", bus.out_result, 12);
    chk("addi_alu_idle", bus.alu_inst_name, OP_NOP);
    tick();
    chk("addi_out_drop", bus.out_valid, 0);

    // ADD rob 2 waiting on rob 5, woken by CDB
    issue(OP_ADD, 0, 1, 1, 5, 0, 0, 0, 0, 2);
    tick();
    bus.issue_valid = 1'b0;
    cdb(1, 5, 32'h10);
    tick();
    cdb(0, 0, 0);
    chk("add_wake_late", bus.alu_inst_name, OP_NOP);
    tick();
    chk("add_disp", bus.alu_inst_name, OP_ADD);
    chk("add_v1", bus.alu_V1, 32'h10);
    tick();
    chk("add_out_vld", bus.out_valid, 1);
    chk("add_out_res", bus.out_result, 32'h11);
    chk("add_out_rob", bus.out_rob_id, 2);

    // BNE taken
    issue(OP_BNE, 1, 2, 0, 0, 0, 0, 8, 32'h100, 7);
    tick();
    bus.issue_valid = 1'b0;
    tick();
    chk("bne_pc", bus.alu_pc, 32'h100);
    tick();
    chk("bne_jump", bus.out_jump, 1);
    chk("bne_tgt", bus.out_target_pc, 32'h108);
    chk("bne_res", bus.out_result, 1);
    chk("bne_rob", bus.out_rob_id, 7);

    // same-cycle CDB bypass at issue
    issue(OP_ADD, 0, 3, 1, 6, 0, 0, 0, 0, 1);
    cdb(1, 6, 9);
    tick();
    bus.issue_valid = 1'b0;
    cdb(0, 0, 0);
    tick();
    chk("byp_disp", bus.alu_inst_name, OP_ADD);
    chk("byp_v1", bus.alu_V1, 9);
    tick();
    chk("byp_res", bus.out_result, 12);
    chk("byp_rob", bus.out_rob_id, 1);

    // fill all entries; entry i waits on tag i, V2=i, rob i
    for (int i = 0; i < 16; i++) begin
      chk("fill_not_full", bus.rs_full, 0);
      issue(OP_ADD, 0, i, 1, 4'(i), 0, 0, 0, 0, 4'(i));
      tick();
    end
    bus.issue_valid = 1'b0;
    chk("full_set", bus.rs_full, 1);
    issue(OP_ADDI, 100, 0, 0, 0, 0, 0, 0, 0, 9);
    tick();
    bus.issue_valid = 1'b0;
    chk("full_still", bus.rs_full, 1);
    tick();
    chk("full_drop_issue", bus.alu_inst_name, OP_NOP);
    cdb(1, 4, 32'h20);
    tick();
    cdb(0, 0, 0);
    chk("full_wake_full", bus.rs_full, 1);
    tick();
    chk("full_e4_disp", bus.alu_V1, 32'h20);
    chk("full_released", bus.rs_full, 0);
    issue(OP_ADDI, 50, 0, 0, 0, 0, 0, 1, 0, 13);
    tick();
    bus.issue_valid = 1'b0;
    chk("refill_full", bus.rs_full, 1);
    chk("e4_out_res", bus.out_result, 32'h24);
    chk("e4_out_rob", bus.out_rob_id, 4);
    chk("refill_not_yet", bus.alu_inst_name, OP_NOP);
    tick();
    chk("refill_disp", bus.alu_inst_name, OP_ADDI);
    chk("refill_full2", bus.rs_full, 0);
    tick();
    chk("refill_res", bus.out_result, 51);
    chk("refill_rob", bus.out_rob_id, 13);

    // flush with a concurrent issue; refill one entry to make pending state
    issue(OP_ADD, 0, 0, 1, 15, 0, 0, 0, 0, 14);
    tick();
    issue(OP_ADDI, 7, 0, 0, 0, 0, 0, 0, 0, 10);
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    bus.issue_valid = 1'b0;
    chk("clr_rs_full", bus.rs_full, 0);
    chk("clr_alu_nop", bus.alu_inst_name, OP_NOP);
    chk("clr_out_vld", bus.out_valid, 0);
    cdb(1, 0, 1);
    tick();
    cdb(0, 0, 0);
    chk("clr_issue_dropped", bus.alu_inst_name, OP_NOP);
    tick();
    chk("clr_entries_gone", bus.alu_inst_name, OP_NOP);

    // rdy_in freeze with a live ALU op
    issue(OP_ADDI, 3, 0, 0, 0, 0, 0, 4, 0, 5);
    tick();
    bus.issue_valid = 1'b0;
    tick();
    chk("frz_disp", bus.alu_inst_name, OP_ADDI);
    rdy_in = 1'b0;
    issue(OP_ADDI, 99, 0, 0, 0, 0, 0, 0, 0, 6);
    cdb(1, 6, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_alu", bus.alu_inst_name, OP_ADDI);
      chk("frz_out_vld", bus.out_valid, 0);
      chk("frz_full", bus.rs_full, 0);
    end
    rdy_in = 1'b1;
    bus.issue_valid = 1'b0;
    cdb(0, 0, 0);
    tick();
    chk("frz_out_res", bus.out_result, 7);
    chk("frz_out_rob", bus.out_rob_id, 5);
    chk("frz_issue_drop", bus.alu_inst_name, OP_NOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
